pipeline_stall_ctrl: RTL
========================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port hazard, input, 1, load-use stall request from the hazard detector (ID reads the rd of a load in ID/EX).
REQ-004 SHALL have port branch_taken, input, 1, taken branch or jump resolved in EX.
REQ-005 SHALL have port mem_busy, input, 1, data memory not ready this cycle.
REQ-006 SHALL have port cnt_clr, input, 1, synchronous clear of all event counters.
REQ-007 SHALL have port pc_write, output, 1, PC register enable.
REQ-008 SHALL have port ifid_write, output, 1, IF/ID register enable.
REQ-009 SHALL have port ifid_flush, output, 1, load NOP into IF/ID.
REQ-010 SHALL have port idex_bubble, output, 1, load NOP (all control zero) into ID/EX.
REQ-011 SHALL have port exmem_hold, output, 1, freeze EX/MEM and MEM/WB.
REQ-012 SHALL have ports stall_cnt, flush_cnt and wait_cnt, output, 16 each, counts of load-use bubbles, branch flushes and memory-wait cycles.

Function
REQ-013 SHALL hold a 2-bit state: RUN=0, LU_STALL=1, MEM_WAIT=2; encoding 3 SHALL go to RUN on the next edge.
REQ-014 SHALL derive control outputs combinationally from state and inputs in the same cycle, with zero latency.
REQ-015 SHALL apply input priority mem_busy > branch_taken > hazard.
REQ-016 If mem_busy=1 in any state: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0, exmem_hold=1; next state MEM_WAIT; wait_cnt +1.
REQ-017 Else if branch_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, exmem_hold=0; next state RUN; flush_cnt +1; a simultaneous hazard SHALL be ignored and SHALL NOT be counted.
REQ-018 Else if hazard=1 and state is RUN or MEM_WAIT: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, exmem_hold=0; next state LU_STALL; stall_cnt +1.
REQ-019 In LU_STALL, hazard SHALL be masked, guaranteeing exactly one bubble per load-use event.
REQ-020 Otherwise (normal): pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, exmem_hold=0; next state RUN.
REQ-021 On leaving MEM_WAIT (mem_busy=0), the same cycle SHALL evaluate branch_taken and hazard per REQ-017/018.
REQ-022 Counters SHALL saturate at 0xFFFF; they SHALL NOT wrap.
REQ-023 If cnt_clr=1, all counters SHALL load 0 on that edge; cnt_clr SHALL take priority over any increment in the same cycle.
REQ-024 The counters SHALL be registered: a count becomes visible on the edge after its event.

Reset
REQ-025 While rst_n=0: state=RUN and all counters=0, applied asynchronously.
REQ-026 While rst_n=0: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_hold=0, regardless of the other inputs.
REQ-027 An assertion of rst_n in the middle of LU_STALL or MEM_WAIT SHALL abort the state, with no counter update.
REQ-028 The first edge after deassertion SHALL operate from RUN.

Verification
REQ-029 Stimulus: RUN, hazard=1 held for 2 cycles. Required: cycle 1 pc_write=0 and idex_bubble=1; cycle 2 normal outputs (masked); stall_cnt=1.
REQ-030 Stimulus: hazard=1 and branch_taken=1 in the same cycle. Required: ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1, stall_cnt=0.
REQ-031 Stimulus: mem_busy=1 for 3 cycles with hazard=1 throughout, then mem_busy=0 and hazard=1. Required: exmem_hold=1 for 3 cycles, wait_cnt=3; next cycle a bubble is issued and stall_cnt=1.
REQ-032 Stimulus: preload stall_cnt=0xFFFE, then 3 load-use events. Required: stall_cnt reads 0xFFFF and holds.
REQ-033 Stimulus: cnt_clr=1 coincident with branch_taken=1. Required: flush_cnt=0 after the edge, while the flush outputs are still asserted that cycle.
REQ-034 Stimulus: rst_n=0 asynchronously mid-MEM_WAIT. Required: immediately exmem_hold=0, idex_bubble=1, all counters 0; after release, state is RUN.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard/stall controller: issues PC/IF-ID enables, flushes and bubbles
// from memory-wait, branch and load-use requests, and keeps saturating event counters.
module pipeline_stall_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hazard,
    input  logic        branch_taken,
    input  logic        mem_busy,
    input  logic        cnt_clr,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_hold,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [15:0] wait_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [2:0] cnt_inc;    // [0] load-use bubble, [1] branch flush, [2] memory wait

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        state_next  = RUN;
        cnt_inc     = 3'b000;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state_reg == ILLEGAL) begin
            // Unreachable encoding: behave as a normal cycle and recover to RUN.
            state_next = RUN;
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
            state_next = MEM_WAIT;
            cnt_inc[2] = 1'b1;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            cnt_inc[1]  = 1'b1;
        end else if (hazard && state_reg != LU_STALL) begin
            // The hazard stays asserted for one cycle after the bubble; LU_STALL masks it.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_next  = LU_STALL;
            cnt_inc[0]  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= 16'd0;
                end else if (cnt_clr) begin
                    cnt_reg <= 16'd0;
                end else if (cnt_inc[gi] && cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign stall_cnt = g_cnt[0].cnt_reg;
    assign flush_cnt = g_cnt[1].cnt_reg;
    assign wait_cnt  = g_cnt[2].cnt_reg;

endmodule
